// File: rtl/stack_cmd_ctrl.sv
// Command front-end for the Merak 4x8 LIFO stack: push/pop/peek over
// valid/ready, single-cycle stack strobes, error guard and occupancy tracking.
module stack_cmd_ctrl #(
   parameter  int DATA_W = 4,
   parameter  int DEPTH  = 8,
   parameter  int ERR_W  = 8,
   localparam int OCC_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              stk_enable,
   output logic              stk_push_pop,
   output logic [DATA_W-1:0] stk_data_in,
   input  logic              stk_full,
   input  logic              stk_empty,
   input  logic [DATA_W-1:0] stk_data_out,
   output logic [OCC_W-1:0]  occupancy,
   output logic [ERR_W-1:0]  err_count,
   output logic              mismatch
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_POP  = 2'b10;
   localparam logic [1:0] OP_PEEK = 2'b11;

   localparam logic [OCC_W-1:0] OCC_FULL0 = OCC_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] OCC_FULL1 = OCC_W'(DEPTH);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_cmd_ready,    w_cmd_ready_nxt;
   logic              r_rsp_valid,    w_rsp_valid_nxt;
   logic [DATA_W-1:0] r_rsp_data,     w_rsp_data_nxt;
   logic              r_rsp_err,      w_rsp_err_nxt;
   logic              r_stk_enable,   w_stk_enable_nxt;
   logic              r_stk_push_pop, w_stk_push_pop_nxt;
   logic [DATA_W-1:0] r_stk_data_in,  w_stk_data_in_nxt;
   logic [OCC_W-1:0]  r_occupancy,    w_occupancy_nxt;
   logic [ERR_W-1:0]  r_err_count,    w_err_count_nxt;
   logic              r_mismatch,     w_mismatch_nxt;
   logic              w_accept;
   logic              w_reject;
   logic              w_occ_empty;
   logic              w_occ_full;

   assign w_accept    = cmd_valid && r_cmd_ready;
   assign w_occ_empty = (r_occupancy == '0);
   assign w_occ_full  = (r_occupancy == OCC_FULL0) ||
                        (r_occupancy == OCC_FULL1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_cmd_ready    <= 1'b0;
         r_rsp_valid    <= 1'b0;
         r_rsp_data     <= '0;
         r_rsp_err      <= 1'b0;
         r_stk_enable   <= 1'b0;
         r_stk_push_pop <= 1'b0;
         r_stk_data_in  <= '0;
         r_occupancy    <= '0;
         r_err_count    <= '0;
         r_mismatch     <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cmd_ready    <= w_cmd_ready_nxt;
         r_rsp_valid    <= w_rsp_valid_nxt;
         r_rsp_data     <= w_rsp_data_nxt;
         r_rsp_err      <= w_rsp_err_nxt;
         r_stk_enable   <= w_stk_enable_nxt;
         r_stk_push_pop <= w_stk_push_pop_nxt;
         r_stk_data_in  <= w_stk_data_in_nxt;
         r_occupancy    <= w_occupancy_nxt;
         r_err_count    <= w_err_count_nxt;
         r_mismatch     <= w_mismatch_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_cmd_ready_nxt    = r_cmd_ready;
      w_rsp_valid_nxt    = r_rsp_valid;
      w_rsp_data_nxt     = r_rsp_data;
      w_rsp_err_nxt      = r_rsp_err;
      w_stk_enable_nxt   = 1'b0;
      w_stk_push_pop_nxt = r_stk_push_pop;
      w_stk_data_in_nxt  = r_stk_data_in;
      w_occupancy_nxt    = r_occupancy;
      w_err_count_nxt    = r_err_count;
      w_mismatch_nxt     = r_mismatch;
      w_reject           = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_cmd_ready_nxt = 1'b1;
            // Stack flags are only meaningful while no strobe is in flight
            if (w_occ_empty != stk_empty || w_occ_full != stk_full)
               w_mismatch_nxt = 1'b1;
            if (w_accept) begin
               unique case (cmd_op)
                  OP_NOP: begin
                  end
                  OP_PUSH: begin
                     if (stk_full) begin
                        w_reject = 1'b1;
                     end else begin
                        w_state_nxt        = ISSUE;
                        w_cmd_ready_nxt    = 1'b0;
                        w_stk_enable_nxt   = 1'b1;
                        w_stk_push_pop_nxt = 1'b1;
                        w_stk_data_in_nxt  = cmd_data;
                        w_rsp_data_nxt     = '0;
                        w_rsp_err_nxt      = 1'b0;
                     end
                  end
                  OP_POP: begin
                     if (stk_empty) begin
                        w_reject = 1'b1;
                     end else begin
                        w_state_nxt        = ISSUE;
                        w_cmd_ready_nxt    = 1'b0;
                        w_stk_enable_nxt   = 1'b1;
                        w_stk_push_pop_nxt = 1'b0;
                        w_rsp_data_nxt     = stk_data_out;
                        w_rsp_err_nxt      = 1'b0;
                     end
                  end
                  OP_PEEK: begin
                     if (stk_empty) begin
                        w_reject = 1'b1;
                     end else begin
                        w_state_nxt     = RESP;
                        w_cmd_ready_nxt = 1'b0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_data_nxt  = stk_data_out;
                        w_rsp_err_nxt   = 1'b0;
                     end
                  end
                  default: begin
                  end
               endcase
               if (w_reject) begin
                  w_state_nxt     = RESP;
                  w_cmd_ready_nxt = 1'b0;
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_data_nxt  = '0;
                  w_rsp_err_nxt   = 1'b1;
                  if (r_err_count != '1)
                     w_err_count_nxt = r_err_count + 1'b1;
               end
            end
         end
         ISSUE: begin
            // Stack commits on the edge that ends this state
            w_state_nxt     = RESP;
            w_rsp_valid_nxt = 1'b1;
            if (r_stk_push_pop)
               w_occupancy_nxt = r_occupancy + 1'b1;
            else
               w_occupancy_nxt = r_occupancy - 1'b1;
         end
         RESP: begin
            if (rsp_ready) begin
               w_state_nxt     = IDLE;
               w_cmd_ready_nxt = 1'b1;
               w_rsp_valid_nxt = 1'b0;
               w_rsp_data_nxt  = '0;
               w_rsp_err_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt     = IDLE;
            w_cmd_ready_nxt = 1'b0;
            w_rsp_valid_nxt = 1'b0;
         end
      endcase
   end

   assign cmd_ready    = r_cmd_ready;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_data     = r_rsp_data;
   assign rsp_err      = r_rsp_err;
   assign stk_enable   = r_stk_enable;
   assign stk_push_pop = r_stk_push_pop;
   assign stk_data_in  = r_stk_data_in;
   assign occupancy    = r_occupancy;
   assign err_count    = r_err_count;
   assign mismatch     = r_mismatch;

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Directed bench for stack_cmd_ctrl with a behavioural 4x8 LIFO
// that reports full at 7 stored words.
module tb_stack_cmd_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_data = 4'h0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [3:0] rsp_data;
   logic       rsp_err;
   logic       stk_enable;
   logic       stk_push_pop;
   logic [3:0] stk_data_in;
   logic       stk_full;
   logic       stk_empty;
   logic [3:0] stk_data_out;
   logic [3:0] occupancy;
   logic [7:0] err_count;
   logic       mismatch;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stack_cmd_ctrl #(.DATA_W(4), .DEPTH(8), .ERR_W(8)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .stk_enable(stk_enable), .stk_push_pop(stk_push_pop),
      .stk_data_in(stk_data_in), .stk_full(stk_full),
      .stk_empty(stk_empty), .stk_data_out(stk_data_out),
      .occupancy(occupancy), .err_count(err_count),
      .mismatch(mismatch)
   );

   // Behavioural stack sharing the reset net
   logic [3:0] mem [0:7];
   logic [3:0] sc = 4'd0;
   assign stk_full     = (sc >= 4'd7);
   assign stk_empty    = (sc == 4'd0);
   assign stk_data_out = stk_empty ? 4'h0 : mem[3'(sc - 4'd1)];

   always @(posedge clk) begin
      if (!reset) sc <= 4'd0;
      else if (stk_enable) begin
         if (stk_push_pop) begin
            if (sc < 4'd8) mem[3'(sc)] <= stk_data_in;
            sc <= sc + 4'd1;
         end else if (sc != 4'd0) sc <= sc - 4'd1;
      end
   end

   // Strobe monitor
   int strobes = 0;
   int push_strobes = 0;
   int long_pulses = 0;
   logic prev_en = 1'b0;
   always @(posedge clk) begin
      if (stk_enable) begin
         strobes++;
         if (stk_push_pop) push_strobes++;
         if (prev_en) long_pulses++;
      end
      prev_en <= stk_enable;
   end

   localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, PEEK = 2'b11;

   task automatic do_cmd(input logic [1:0] op, input logic [3:0] d,
                         output logic [3:0] rd, output logic re,
                         output int lat, output bit ok);
      ok = 0; lat = 0; rd = 4'h0; re = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
      if (!cmd_ready) begin
         cmd_valid = 1'b0;
         return;
      end
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = NOP;
      lat = 1;
      for (int i = 0; i < 20 && !rsp_valid; i++) begin
         @(negedge clk);
         lat++;
      end
      if (rsp_valid) begin
         rd = rsp_data; re = rsp_err; ok = 1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, rsp_data, rsp_err, stk_enable,
           stk_push_pop, stk_data_in, occupancy, err_count, mismatch} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h re=%b en=%b occ=%0d ec=%0d mm=%b, want all 0",
                  cmd_ready, rsp_valid, rsp_data, rsp_err, stk_enable, occupancy, err_count, mismatch);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_push3;
      logic [3:0] vals [3];
      logic [3:0] rd; logic re; int lat; bit ok;
      int s0, p0;
      vals[0] = 4'h3; vals[1] = 4'hA; vals[2] = 4'h5;
      s0 = strobes; p0 = push_strobes;
      for (int i = 0; i < 3; i++) begin
         do_cmd(PUSH, vals[i], rd, re, lat, ok);
         checks++;
         if (!ok || rd !== 4'h0 || re !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL push_rsp[%0d]: ok=%0d data=%h err=%b lat=%0d, want 1/0/0/2", i, ok, rd, re, lat);
         end
      end
      @(negedge clk);
      checks++;
      if (strobes - s0 != 3 || push_strobes - p0 != 3 || long_pulses != 0) begin
         errors++;
         $display("FAIL push_strobes: got %0d push %0d long %0d, want 3/3/0",
                  strobes - s0, push_strobes - p0, long_pulses);
      end
      checks++;
      if (occupancy !== 4'd3) begin
         errors++;
         $display("FAIL push_occ: got %0d want 3", occupancy);
      end
   endtask

   task automatic test_peek_pop;
      logic [3:0] exp [4];
      logic [3:0] rd; logic re; int lat; bit ok;
      int s0, p0;
      exp[0] = 4'h5; exp[1] = 4'h5; exp[2] = 4'hA; exp[3] = 4'h3;
      s0 = strobes; p0 = push_strobes;
      do_cmd(PEEK, 4'h0, rd, re, lat, ok);
      checks++;
      if (!ok || rd !== exp[0] || re !== 1'b0 || lat != 1 || strobes != s0) begin
         errors++;
         $display("FAIL peek_rsp: ok=%0d data=%h err=%b lat=%0d strb=%0d, want 1/5/0/1/0",
                  ok, rd, re, lat, strobes - s0);
      end
      for (int i = 1; i < 4; i++) begin
         do_cmd(POP, 4'h0, rd, re, lat, ok);
         checks++;
         if (!ok || rd !== exp[i] || re !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL pop_rsp[%0d]: ok=%0d data=%h err=%b lat=%0d, want 1/%h/0/2",
                     i, ok, rd, re, lat, exp[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (occupancy !== 4'd0 || strobes - s0 != 3 || push_strobes != p0) begin
         errors++;
         $display("FAIL pop_final: occ=%0d strb=%0d push=%0d, want 0/3/0",
                  occupancy, strobes - s0, push_strobes - p0);
      end
   endtask

   task automatic test_underflow;
      logic [3:0] rd; logic re; int lat; bit ok;
      int s0;
      s0 = strobes;
      do_cmd(POP, 4'h0, rd, re, lat, ok);
      @(negedge clk);
      checks++;
      if (!ok || rd !== 4'h0 || re !== 1'b1 || lat != 1 ||
          strobes != s0 || err_count !== 8'd1) begin
         errors++;
         $display("FAIL underflow_pop: ok=%0d data=%h err=%b lat=%0d strb=%0d ec=%0d, want 1/0/1/1/0/1",
                  ok, rd, re, lat, strobes - s0, err_count);
      end
      do_cmd(PEEK, 4'h0, rd, re, lat, ok);
      @(negedge clk);
      checks++;
      if (!ok || rd !== 4'h0 || re !== 1'b1 || err_count !== 8'd2) begin
         errors++;
         $display("FAIL underflow_peek: ok=%0d data=%h err=%b ec=%0d, want 1/0/1/2",
                  ok, rd, re, err_count);
      end
   endtask

   task automatic test_overflow;
      logic [3:0] rd; logic re; int lat; bit ok;
      int s0;
      for (int i = 0; i < 7; i++) begin
         do_cmd(PUSH, 4'(i + 1), rd, re, lat, ok);
         checks++;
         if (!ok || re !== 1'b0) begin
            errors++;
            $display("FAIL fill_push[%0d]: ok=%0d err=%b, want 1/0", i, ok, re);
         end
      end
      @(negedge clk);
      checks++;
      if (occupancy !== 4'd7 || stk_full !== 1'b1) begin
         errors++;
         $display("FAIL fill_state: occ=%0d full=%b, want 7/1", occupancy, stk_full);
      end
      s0 = strobes;
      do_cmd(PUSH, 4'hF, rd, re, lat, ok);
      @(negedge clk);
      checks++;
      if (!ok || re !== 1'b1 || rd !== 4'h0 || strobes != s0 || err_count !== 8'd3) begin
         errors++;
         $display("FAIL overflow_push: ok=%0d err=%b data=%h strb=%0d ec=%0d, want 1/1/0/0/3",
                  ok, re, rd, strobes - s0, err_count);
      end
      do_cmd(PEEK, 4'h0, rd, re, lat, ok);
      checks++;
      if (!ok || rd !== 4'h7 || re !== 1'b0) begin
         errors++;
         $display("FAIL overflow_top: ok=%0d data=%h err=%b, want 1/7/0", ok, rd, re);
      end
      @(negedge clk);
      checks++;
      if (mismatch !== 1'b0) begin
         errors++;
         $display("FAIL overflow_mismatch: got %b want 0", mismatch);
      end
   endtask

   task automatic test_backpressure;
      bit stable;
      rsp_ready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = POP;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_before: got %b want 1", cmd_ready);
      end
      @(negedge clk);
      cmd_op = PEEK;
      @(negedge clk);
      stable = 1;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid !== 1'b1 || rsp_data !== 4'h7 ||
             rsp_err !== 1'b0 || cmd_ready !== 1'b0) stable = 0;
         if (i < 4) @(negedge clk);
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL bp_hold: rv=%b data=%h err=%b rdy=%b, want held 1/7/0/0",
                  rsp_valid, rsp_data, rsp_err, cmd_ready);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: rdy=%b rv=%b, want 1/0", cmd_ready, rsp_valid);
      end
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = NOP;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 4'h6 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL bp_late_peek: rv=%b data=%h err=%b, want 1/6/0", rsp_valid, rsp_data, rsp_err);
      end
      @(negedge clk);
      checks++;
      if (occupancy !== 4'd6 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_final: occ=%0d rdy=%b, want 6/1", occupancy, cmd_ready);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 4'h9;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = NOP;
      checks++;
      if (stk_enable !== 1'b1) begin
         errors++;
         $display("FAIL mid_issue: en=%b want 1", stk_enable);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (stk_enable !== 1'b0 || rsp_valid !== 1'b0 || occupancy !== 4'd0 ||
          cmd_ready !== 1'b0 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset: en=%b rv=%b occ=%0d rdy=%b ec=%0d, want 0/0/0/0/0",
                  stk_enable, rsp_valid, occupancy, cmd_ready, err_count);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || stk_enable !== 1'b0) begin
         errors++;
         $display("FAIL mid_release: rdy=%b rv=%b en=%b, want 1/0/0", cmd_ready, rsp_valid, stk_enable);
      end
   endtask

   task automatic test_saturate;
      logic [3:0] rd; logic re; int lat; bit ok;
      int nok;
      nok = 0;
      for (int i = 0; i < 255; i++) begin
         do_cmd(POP, 4'h0, rd, re, lat, ok);
         if (!ok || re !== 1'b1) nok++;
      end
      @(negedge clk);
      checks++;
      if (err_count !== 8'd255 || nok != 0) begin
         errors++;
         $display("FAIL sat_255: ec=%0d bad_rsp=%0d, want 255/0", err_count, nok);
      end
      for (int i = 0; i < 5; i++) do_cmd(PEEK, 4'h0, rd, re, lat, ok);
      @(negedge clk);
      checks++;
      if (err_count !== 8'd255 || mismatch !== 1'b0) begin
         errors++;
         $display("FAIL sat_hold: ec=%0d mm=%b, want 255/0", err_count, mismatch);
      end
   endtask

   initial begin
      test_reset();
      test_push3();
      test_peek_pop();
      test_underflow();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
